int_ctrl: RTL and testbench

// Parametrised interrupt controller for the 6502 core family. It generalises the core's fixed rst/nmi/irq handling to NUM_IRQ

---
 rtl/int_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_int_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: parametrised interrupt controller for the 6502 core family.
// Takes the reset request, the nmi input and NUM_IRQ maskable irq channels, and
// presents one registered request plus the vector of the winning source to the core.
// Optional feature: define INT_PRIO_ROTATE_EN for round-robin priority among IRQ
// channels. When it is not defined, priority is fixed and the lowest index wins.
module int_ctrl #(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b0}},
    parameter logic [NUM_IRQ-1:0] MASK_RST    = {NUM_IRQ{1'b1}},
    parameter logic [15:0]        NMI_VECTOR  = 16'hfffa,
    parameter logic [15:0]        RST_VECTOR  = 16'hfffc,
    parameter logic [15:0]        IRQ_VECTOR  = 16'hfffe,
    parameter logic [15:0]        IRQ_TABLE   = 16'hffe0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nmi,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               i_flag,
    input  logic               sync,
    input  logic               rdy,
    input  logic               handle_int,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               interrupt,
    output logic               rst_event,
    output logic [15:0]        vector,
    output logic [4:0]         src_id,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int         IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [4:0] ID_RST = 5'h1f;
    localparam logic [4:0] ID_NMI = 5'h10;

    typedef enum logic {IDLE, LATCHED} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ:0]   raw_in, syn_in;
    logic               nmi_s, nmi_prev, nmi_rise, nmi_pend;
    logic [NUM_IRQ-1:0] irq_s, irq_prev, irq_rise;
    logic [NUM_IRQ-1:0] edge_pend, mask, eligible, ack_hot;
    logic               capture, ack, ack_rst, ack_nmi, ack_irq;
    logic [IDX_W-1:0]   ack_idx, cand_idx;
    logic               cand_valid, irq_hit;
    logic [4:0]         cand_id, lat_id;
    logic [15:0]        cand_vec, lat_vec;

    // Vector address for a source id; ids that are not IRQ channels map to their fixed vectors.
    function automatic logic [15:0] vec_of(input logic [4:0] id);
        if (id == ID_RST) return RST_VECTOR;
        if (id == ID_NMI) return NMI_VECTOR;
        if (id == 5'd0)   return IRQ_VECTOR;
        return IRQ_TABLE + {10'd0, id, 1'b0};
    endfunction

    // nmi rides along with the irq lines through the synchroniser as the top bit.
    assign raw_in = {nmi, irq};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign syn_in = raw_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NUM_IRQ:0] chain;
            // Shift raw requests through the synchroniser flops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= raw_in;
                    for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
                end
            end
            assign syn_in = chain[SYNC_STAGES-1];
        end
    endgenerate

    assign nmi_s    = syn_in[NUM_IRQ];
    assign irq_s    = syn_in[NUM_IRQ-1:0];
    assign nmi_rise = nmi_s & ~nmi_prev;
    assign irq_rise = irq_s & ~irq_prev;

    // Edge channels report their latch; level channels follow the synchronised line.
    assign pending  = (edge_pend & EDGE_MASK) | (irq_s & ~EDGE_MASK);
    assign eligible = pending & mask & {NUM_IRQ{~i_flag}};

    // Edge history: previous synchronised value of every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_prev <= 1'b0;
            irq_prev <= '0;
        end else begin
            nmi_prev <= nmi_s;
            irq_prev <= irq_s;
        end
    end

`ifdef INT_PRIO_ROTATE_EN
    logic [IDX_W-1:0] ptr;
    int               rr_idx;

    // Round-robin pointer: after ack of channel k the search starts at k+1.
    always_ff @(posedge clk) begin
        if (rst)          ptr <= '0;
        else if (ack_irq) ptr <= (ack_idx == IDX_W'(NUM_IRQ - 1)) ? '0 : ack_idx + 1'b1;
    end

    // IRQ winner: first eligible channel at or after the pointer, wrapping around.
    always_comb begin
        irq_hit  = 1'b0;
        cand_idx = '0;
        rr_idx   = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            rr_idx = (int'(ptr) + i) % NUM_IRQ;
            if (!irq_hit && eligible[rr_idx]) begin
                irq_hit  = 1'b1;
                cand_idx = IDX_W'(rr_idx);
            end
        end
    end
`else
    // IRQ winner: lowest eligible index (scan downwards so the lowest hit lands last).
    always_comb begin
        irq_hit  = 1'b0;
        cand_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_hit  = 1'b1;
                cand_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Overall candidate: reset outranks nmi, which outranks every IRQ channel.
    always_comb begin
        cand_valid = 1'b1;
        cand_id    = ID_RST;
        if (rst_event) begin
            cand_id = ID_RST;
        end else if (nmi_pend) begin
            cand_id = ID_NMI;
        end else if (irq_hit) begin
            cand_id = 5'(cand_idx);
        end else begin
            cand_valid = 1'b0;
        end
        cand_vec = vec_of(cand_id);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture on an opcode fetch while requesting; release on the core's acknowledge.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE: begin
                if (sync && rdy && interrupt && cand_valid) begin
                    capture   = 1'b1;
                    state_nxt = LATCHED;
                end
            end
            LATCHED: begin
                if (handle_int) begin
                    ack       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Freeze the winner's id and vector at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_id  <= ID_RST;
            lat_vec <= RST_VECTOR;
        end else if (capture) begin
            lat_id  <= cand_id;
            lat_vec <= cand_vec;
        end
    end

    assign ack_rst = ack && (lat_id == ID_RST);
    assign ack_nmi = ack && (lat_id == ID_NMI);
    assign ack_irq = ack && !ack_rst && !ack_nmi;
    assign ack_idx = lat_id[IDX_W-1:0];
    assign ack_hot = ack_irq ? (NUM_IRQ'(1) << ack_idx) : '0;

    // Reset sequence stays pending until the core acknowledges it.
    always_ff @(posedge clk) begin
        if (rst)          rst_event <= 1'b1;
        else if (ack_rst) rst_event <= 1'b0;
    end

    // nmi latch: a new edge wins over a clear, so an edge arriving with an ack is kept.
    always_ff @(posedge clk) begin
        if (rst)           nmi_pend <= 1'b0;
        else if (nmi_rise) nmi_pend <= 1'b1;
        else if (ack_nmi)  nmi_pend <= 1'b0;
    end

    // Edge-channel latches: set on a rising edge, cleared by ack unless a new edge coincides.
    always_ff @(posedge clk) begin
        if (rst) edge_pend <= '0;
        else     edge_pend <= ((edge_pend & ~ack_hot) | irq_rise) & EDGE_MASK;
    end

    // Mask register; a write becomes visible on the following cycle.
    always_ff @(posedge clk) begin
        if (rst)          mask <= MASK_RST;
        else if (mask_we) mask <= mask_wdata;
    end

    // Registered request to the core.
    always_ff @(posedge clk) begin
        if (rst) interrupt <= 1'b1;
        else     interrupt <= rst_event | nmi_pend | (|eligible);
    end

    // Latched source while serviced; otherwise the live candidate for debug.
    assign vector = (state == LATCHED) ? lat_vec : cand_vec;
    assign src_id = (state == LATCHED) ? lat_id  : cand_id;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_int_ctrl;

    localparam int         N    = 8;
    localparam int         S    = 2;
    localparam logic [7:0] EDGE = 8'h04;

    logic        clk = 1'b0;
    logic        rst, nmi, i_flag, sync, rdy, handle_int, mask_we;
    logic [7:0]  irq, mask_wdata, pending;
    logic        interrupt, rst_event;
    logic [15:0] vector;
    logic [4:0]  src_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    int_ctrl #(
        .NUM_IRQ(N), .SYNC_STAGES(S), .EDGE_MASK(EDGE), .MASK_RST(8'hff),
        .NMI_VECTOR(16'hfffa), .RST_VECTOR(16'hfffc), .IRQ_VECTOR(16'hfffe), .IRQ_TABLE(16'hffe0)
    ) dut (
        .clk(clk), .rst(rst), .nmi(nmi), .irq(irq), .i_flag(i_flag), .sync(sync), .rdy(rdy),
        .handle_int(handle_int), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .interrupt(interrupt), .rst_event(rst_event), .vector(vector), .src_id(src_id),
        .pending(pending)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset, then let the core take and acknowledge the reset sequence.
    task automatic clean_reset();
        rst = 1'b1; step(); rst = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        handle_int = 1'b1; step(); handle_int = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); rst = 1'b0;
        tests++; if (rst_event !== 1'b1) begin fails++; $display("FAIL reset_rst_event got %b want 1", rst_event); end
        tests++; if (interrupt !== 1'b1) begin fails++; $display("FAIL reset_interrupt got %b want 1", interrupt); end
        tests++; if (vector !== 16'hfffc) begin fails++; $display("FAIL reset_vector got %h want fffc", vector); end
        tests++; if (src_id !== 5'h1f) begin fails++; $display("FAIL reset_src_id got %h want 1f", src_id); end
        tests++; if (pending !== 8'h00) begin fails++; $display("FAIL reset_pending got %h want 00", pending); end
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'h1f || vector !== 16'hfffc) begin fails++; $display("FAIL rst_latched got %h/%h want 1f/fffc", src_id, vector); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (rst_event !== 1'b0) begin fails++; $display("FAIL rst_ack_event got %b want 0", rst_event); end
        step();
        tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL rst_ack_interrupt got %b want 0", interrupt); end
    endtask

    task automatic test_level();
        irq = 8'h0a; step(2);
        tests++; if (pending !== 8'h0a) begin fails++; $display("FAIL level_pending got %h want 0a", pending); end
        step();
        tests++; if (interrupt !== 1'b1) begin fails++; $display("FAIL level_interrupt got %b want 1", interrupt); end
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'd1 || vector !== 16'hffe2) begin fails++; $display("FAIL level_capture got %h/%h want 01/ffe2", src_id, vector); end
        i_flag = 1'b1; step();
        tests++; if (src_id !== 5'd1) begin fails++; $display("FAIL level_iflag_hold got %h want 01", src_id); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL level_iflag_block got %b want 0", interrupt); end
        irq = 8'h00; i_flag = 1'b0; step(3);
    endtask

    task automatic test_edge();
        irq = 8'h04; step(); irq = 8'h00; step(2);
        tests++; if (pending !== 8'h04) begin fails++; $display("FAIL edge_set got %h want 04", pending); end
        step();
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'd2 || vector !== 16'hffe4) begin fails++; $display("FAIL edge_capture got %h/%h want 02/ffe4", src_id, vector); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (pending !== 8'h00) begin fails++; $display("FAIL edge_clear got %h want 00", pending); end
        irq = 8'h04; step(); irq = 8'h00; step(3);
        sync = 1'b1; step(); sync = 1'b0;
        // third pulse timed so its edge reaches the latch on the acknowledge cycle
        irq = 8'h04; step(); irq = 8'h00; step();
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (pending !== 8'h04) begin fails++; $display("FAIL edge_on_ack got %h want 04", pending); end
        step();
        sync = 1'b1; step(); sync = 1'b0;
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (pending !== 8'h00) begin fails++; $display("FAIL edge_final_clear got %h want 00", pending); end
        step(2);
    endtask

    task automatic test_nmi();
        irq = 8'h01; step(3);
        nmi = 1'b1; step(3);
        tests++; if (src_id !== 5'h10 || vector !== 16'hfffa) begin fails++; $display("FAIL nmi_candidate got %h/%h want 10/fffa", src_id, vector); end
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'h10) begin fails++; $display("FAIL nmi_capture got %h want 10", src_id); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        step(4);
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'd0 || vector !== 16'hfffe) begin fails++; $display("FAIL nmi_no_retrigger got %h/%h want 00/fffe", src_id, vector); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        nmi = 1'b0; irq = 8'h00; step(3);
    endtask

    task automatic test_mask();
        irq = 8'h01; step(3);
        mask_we = 1'b1; mask_wdata = 8'hfe; step(); mask_we = 1'b0;
        step();
        tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL mask_block got %b want 0", interrupt); end
        irq = 8'h03; step(3);
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'd1) begin fails++; $display("FAIL mask_capture got %h want 01", src_id); end
        rst = 1'b1; step(); rst = 1'b0;
        tests++; if (rst_event !== 1'b1 || interrupt !== 1'b1 || src_id !== 5'h1f || vector !== 16'hfffc || pending !== 8'h00) begin
            fails++; $display("FAIL mid_latched_reset got %b %b %h %h %h want 1 1 1f fffc 00", rst_event, interrupt, src_id, vector, pending);
        end
        sync = 1'b1; step(); sync = 1'b0;
        handle_int = 1'b1; step(); handle_int = 1'b0;
        step();
        tests++; if (src_id !== 5'd0 || pending !== 8'h03) begin fails++; $display("FAIL mask_reset_value got %h/%h want 00/03", src_id, pending); end
        // capture and mask write on the same edge: the old mask still selects channel 0
        sync = 1'b1; mask_we = 1'b1; mask_wdata = 8'h00; step(); sync = 1'b0; mask_we = 1'b0;
        tests++; if (src_id !== 5'd0) begin fails++; $display("FAIL mask_old_on_capture got %h want 00", src_id); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        tests++; if (interrupt !== 1'b0) begin fails++; $display("FAIL mask_zero got %b want 0", interrupt); end
        mask_we = 1'b1; mask_wdata = 8'hff; step(); mask_we = 1'b0;
        irq = 8'h00; step(3);
    endtask

    task automatic test_rotate();
        logic [4:0] exp2;
`ifdef INT_PRIO_ROTATE_EN
        exp2 = 5'd1;
`else
        exp2 = 5'd0;
`endif
        irq = 8'h03; step(3);
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== 5'd0) begin fails++; $display("FAIL prio_first got %h want 00", src_id); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        tests++; if (src_id !== exp2) begin fails++; $display("FAIL prio_second got %h want %h", src_id, exp2); end
        handle_int = 1'b1; step(); handle_int = 1'b0;
        irq = 8'h00; step(3);
    endtask

    // ---------------- behavioural reference model ----------------
    bit [8:0] m_dq[$];        // synchroniser delay line, oldest sample at the front
    bit [8:0] m_prev;
    bit       m_rst_ev, m_nmi_pend, m_int, m_lat;
    bit [7:0] m_epend, m_mask;
    int       m_lat_id, m_ptr;

    function automatic bit [8:0] m_syn();
        bit [8:0] raw;
        raw = {nmi, irq};
        if (S == 0) return raw;
        return m_dq[0];
    endfunction

    function automatic bit [7:0] m_elig();
        bit [8:0] syn;
        bit [7:0] pend;
        syn  = m_syn();
        pend = (EDGE & m_epend) | (~EDGE & syn[7:0]);
        return i_flag ? 8'h00 : (pend & m_mask);
    endfunction

    function automatic int m_cand(input bit [7:0] elig);
        if (m_rst_ev)   return 31;
        if (m_nmi_pend) return 16;
`ifdef INT_PRIO_ROTATE_EN
        for (int i = 0; i < N; i++) if (elig[(m_ptr + i) % N]) return (m_ptr + i) % N;
`else
        for (int i = 0; i < N; i++) if (elig[i]) return i;
`endif
        return -1;
    endfunction

    function automatic logic [15:0] m_vec(input int id);
        if (id == 31 || id < 0) return 16'hfffc;
        if (id == 16) return 16'hfffa;
        if (id == 0)  return 16'hfffe;
        return 16'hffe0 + 16'(2 * id);
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic m_step();
        bit [8:0] raw, syn;
        bit [7:0] elig;
        int       c;
        bit       new_int;
        raw = {nmi, irq};
        if (rst) begin
            m_dq.delete();
            for (int i = 0; i < S; i++) m_dq.push_back(9'd0);
            m_prev = '0; m_rst_ev = 1'b1; m_nmi_pend = 1'b0; m_int = 1'b1; m_lat = 1'b0;
            m_epend = '0; m_mask = 8'hff; m_lat_id = 31; m_ptr = 0;
            return;
        end
        syn     = m_syn();
        elig    = m_elig();
        c       = m_cand(elig);
        new_int = m_rst_ev | m_nmi_pend | (elig != 0);
        if (!m_lat) begin
            if (sync && rdy && m_int && c >= 0) begin m_lat = 1'b1; m_lat_id = c; end
        end else if (handle_int) begin
            m_lat = 1'b0;
            if (m_lat_id == 31)      m_rst_ev = 1'b0;
            else if (m_lat_id == 16) m_nmi_pend = 1'b0;
            else begin
                m_epend[m_lat_id] = 1'b0;
                m_ptr = (m_lat_id + 1) % N;
            end
        end
        if (syn[8] && !m_prev[8]) m_nmi_pend = 1'b1;
        m_epend = m_epend | (syn[7:0] & ~m_prev[7:0] & EDGE);
        if (mask_we) m_mask = mask_wdata;
        m_int  = new_int;
        m_prev = syn;
        if (S > 0) begin m_dq.push_back(raw); void'(m_dq.pop_front()); end
    endtask

    task automatic test_random();
        bit [8:0] syn;
        bit [7:0] exp_pend;
        int       c, exp_id;
        rst = 1'b1; m_step(); step(); rst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst        = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 7) == 0) nmi = ~nmi;
            for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            if ($urandom_range(0, 9) == 0) i_flag = ~i_flag;
            sync       = ($urandom_range(0, 2) == 0);
            rdy        = ($urandom_range(0, 3) != 0);
            handle_int = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom);
            m_step();
            step();
            syn      = m_syn();
            exp_pend = (EDGE & m_epend) | (~EDGE & syn[7:0]);
            c        = m_cand(m_elig());
            exp_id   = m_lat ? m_lat_id : c;
            tests++; if (interrupt !== m_int) begin fails++; $display("FAIL rnd_interrupt cyc %0d got %b want %b", cyc, interrupt, m_int); end
            tests++; if (rst_event !== m_rst_ev) begin fails++; $display("FAIL rnd_rst_event cyc %0d got %b want %b", cyc, rst_event, m_rst_ev); end
            tests++; if (pending !== exp_pend) begin fails++; $display("FAIL rnd_pending cyc %0d got %h want %h", cyc, pending, exp_pend); end
            tests++; if (vector !== m_vec(exp_id)) begin fails++; $display("FAIL rnd_vector cyc %0d got %h want %h", cyc, vector, m_vec(exp_id)); end
            if (exp_id >= 0) begin
                tests++; if (src_id !== 5'(exp_id)) begin fails++; $display("FAIL rnd_src_id cyc %0d got %h want %h", cyc, src_id, 5'(exp_id)); end
            end
        end
        rst = 1'b0; sync = 1'b0; handle_int = 1'b0; mask_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; nmi = 1'b0; irq = 8'h00; i_flag = 1'b0; sync = 1'b0; rdy = 1'b1;
        handle_int = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
        test_reset();
        clean_reset();
        test_level();
        test_edge();
        test_nmi();
        test_mask();
        test_rotate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
